// File: rtl/uart_rx.sv
// 8N1 UART receiver with its own mid-bit timing, re-aligned on each start bit.
// Delivers bytes over valid/ready; framing and overrun errors are one-cycle pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic          rx_m, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          half_hit, full_hit;
   logic          stop_smp, load, drop, bad_stop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign half_hit = (cnt == HALF);
   assign full_hit = (cnt == FULL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!rx_s) state_nxt = START;
         START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
         DATA:    if (full_hit && bit_idx == 3'd7) state_nxt = STOP;
         STOP:    if (full_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stop-bit sample decides between delivery, overrun drop and framing error.
   always_comb begin
      stop_smp = (state == STOP) && full_hit;
      load     = stop_smp && rx_s && (!data_valid || data_ready);
      drop     = stop_smp && rx_s && data_valid && !data_ready;
      bad_stop = stop_smp && !rx_s;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         busy      <= (state_nxt != IDLE);
         frame_err <= bad_stop;
         overrun   <= drop;
         if (load) begin
            data_out   <= shift;
            data_valid <= 1'b1;
         end else if (data_ready) begin
            data_valid <= 1'b0;
         end
         case (state)
            IDLE: cnt <= '0;
            START: begin
               cnt     <= half_hit ? '0 : cnt + 1'b1;
               bit_idx <= '0;
            end
            DATA: begin
               if (full_hit) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[7:1]};
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP:    cnt <= full_hit ? '0 : cnt + 1'b1;
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model (schedule of stop-sample edges)
// compared every cycle, plus literal checks on the directed scenarios.
module tb_uart_rx;
   localparam int C = 8;

   logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, frame_err, overrun, busy;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // s: first edge rx is low; fin: edge where the receiver decides and returns idle
   typedef struct {
      int         s;
      int         fin;
      logic [7:0] b;
      logic       st;
      logic       is_frame;
   } ev_t;

   ev_t  q[$];
   int   E = 0;
   int   n_chk = 0, n_fail = 0;
   logic [7:0] m_data = 8'h00;
   logic m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_busy;
   int   rise_edge = -1, ferr_cnt = 0, ovr_cnt = 0, dv_rise_cnt = 0;
   logic prev_dv = 1'b0;
   bit   rnd_dr = 1'b0;

   always @(posedge clk) E <= E + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, E);
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      int  L;
      L = E - 1;
      if (!rst) begin
         m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         q.delete();
      end
      m_busy = (q.size() > 0) && (L >= q[0].s + 2) && (L < q[0].fin);
      chk("data_out", data_out, m_data);
      chk("data_valid", data_valid, m_valid);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_busy);
      if (data_valid && !prev_dv) begin rise_edge = L; dv_rise_cnt++; end
      prev_dv = data_valid;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      // predict the effect of the upcoming edge
      if (rst) begin
         m_ferr = 1'b0; m_ovr = 1'b0;
         if (q.size() > 0 && q[0].fin == E) begin
            e = q.pop_front();
            if (e.is_frame && e.st) begin
               if (!m_valid || data_ready) begin m_data = e.b; m_valid = 1'b1; end
               else m_ovr = 1'b1;
            end else begin
               if (e.is_frame) m_ferr = 1'b1;
               if (m_valid && data_ready) m_valid = 1'b0;
            end
         end else if (m_valid && data_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_dr) data_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push_glitch(input int s);
      ev_t g;
      g.s = s; g.fin = s + 2 + C / 2; g.b = 8'h00; g.st = 1'b1; g.is_frame = 1'b0;
      q.push_back(g);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic st);
      ev_t e;
      e.s = E; e.fin = E + 2 + C / 2 + 9 * C; e.b = b; e.st = st; e.is_frame = 1'b1;
      q.push_back(e);
      // a low stop bit is still low when the receiver goes idle: it restarts and aborts
      if (!st) push_glitch(e.fin - 1);
      rx = 1'b0;
      repeat (C) tick();
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         repeat (C) tick();
      end
      rx = st;
      repeat (C) tick();
      rx = 1'b1;
   endtask

   task automatic send_glitch();
      push_glitch(E);
      rx = 1'b0;
      tick();
      tick();
      rx = 1'b1;
   endtask

   task automatic consume();
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
   endtask

   initial begin
      int s0, f0, o0, r0, gap;
      ev_t e;
      repeat (3) tick();
      chk("reset_dv", data_valid, 1'b0);
      chk("reset_data", data_out, 8'h00);
      chk("reset_busy", busy, 1'b0);
      rst = 1'b1;
      repeat (4) tick();

      // 0xA5, consumer stalled
      s0 = E;
      send_frame(8'hA5, 1'b1);
      chk("t1_rise_edge", rise_edge - s0, 78);
      chk("t1_data", data_out, 8'hA5);
      repeat (5) tick();
      chk("t1_hold", data_valid, 1'b1);
      consume();
      chk("t1_clear", data_valid, 1'b0);

      // start-bit glitch then 0x3C
      repeat (C) tick();
      f0 = ferr_cnt; o0 = ovr_cnt; r0 = dv_rise_cnt;
      send_glitch();
      repeat (2 * C) tick();
      chk("t2_no_valid", dv_rise_cnt - r0, 0);
      chk("t2_no_err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
      send_frame(8'h3C, 1'b1);
      chk("t2_data", data_out, 8'h3C);
      consume();

      // bad stop bit, then 0x0F
      repeat (C) tick();
      f0 = ferr_cnt; r0 = dv_rise_cnt;
      send_frame(8'h55, 1'b0);
      repeat (C) tick();
      chk("t3_ferr_once", ferr_cnt - f0, 1);
      chk("t3_no_valid", dv_rise_cnt - r0, 0);
      send_frame(8'h0F, 1'b1);
      chk("t3_data", data_out, 8'h0F);
      consume();

      // overrun
      repeat (C) tick();
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1);
      repeat (C) tick();
      send_frame(8'h22, 1'b1);
      repeat (4) tick();
      chk("t4_data", data_out, 8'h11);
      chk("t4_ovr_once", ovr_cnt - o0, 1);
      consume();
      chk("t4_clear", data_valid, 1'b0);

      // back-to-back, consumer always ready
      data_ready = 1'b1;
      r0 = dv_rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      repeat (4) tick();
      chk("t5_three_bytes", dv_rise_cnt - r0, 3);
      chk("t5_no_err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
      chk("t5_last", data_out, 8'h81);
      data_ready = 1'b0;

      // reset mid-frame at bit 4 of 0xF0 (upper bits high, so no false start)
      repeat (C) tick();
      r0 = dv_rise_cnt;
      e.s = E; e.fin = E + 2 + C / 2 + 9 * C; e.b = 8'hF0; e.st = 1'b1; e.is_frame = 1'b1;
      q.push_back(e);
      rx = 1'b0;
      repeat (5 * C) tick();
      rx = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("t6_rst_data", data_out, 8'h00);
      chk("t6_rst_busy", busy, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (5 * C) tick();
      chk("t6_no_byte", dv_rise_cnt - r0, 0);
      send_frame(8'hC3, 1'b1);
      chk("t6_data", data_out, 8'hC3);
      consume();

      // randomized traffic with random backpressure
      rnd_dr = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic st;
         st = ($urandom_range(0, 7) != 0);
         send_frame(8'($urandom), st);
         gap = st ? $urandom_range(0, 12) : C + $urandom_range(0, 4);
         repeat (gap) tick();
         if ($urandom_range(0, 9) == 0) begin
            send_glitch();
            repeat (C) tick();
         end
      end
      rnd_dr = 1'b0;
      data_ready = 1'b1;
      repeat (2 * C) tick();
      chk("drained", q.size(), 0);
      chk("final_dv", data_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
